keypad_scanner: RTL
===================

// Module: keypad_scanner
// PURPOSE
//  Drives a 4x4 matrix keypad and produces the key/key_valid stream consumed by the
//  alarm controller FSM and key buffer register: the transmitting end of that interface.
//  Scans columns, synchronises and debounces rows, encodes the press to a 4-bit code.
//  Emits one single-cycle key_valid per debounced press, then waits for a debounced release.
// PARAMETERS
//  SCAN_DIV         4096  clocks per scan tick (column dwell); must be >= 4
//  DEBOUNCE_CYCLES  8     consecutive stable ticks needed to accept a press or a release; >= 1
// PORTS
//  clock      in   1  system clock
//  reset      in   1  asynchronous, active-high
//  row_in     in   4  keypad rows, active-low (pulled up externally), asynchronous
//  col_out    out  4  column drive, active-low, exactly one bit low at all times
//  key        out  4  code of last accepted key; held until the next accepted key
//  key_valid  out  1  one-clock pulse when key is updated
//  key_held   out  1  high while an accepted key has not yet been released (debounced)
// BEHAVIOUR
//  Reset values: col_out=4'b1110 (col_idx=0), key=0, key_valid=0, key_held=0, state SCAN,
//   all counters 0, synchroniser flops 4'b1111.
//  Input sync: row_in passes through a 2-flop synchroniser; rows_s is the sampled value.
//  Tick: divider counts 0..SCAN_DIV-1 and wraps; tick=1 in the cycle div==SCAN_DIV-1.
//   Free-running; never reset except by reset.
//  col_out = ~(4'b0001 << col_idx) at all times.
//  Valid sample: on a tick, rows_s has exactly one bit low. All-high means none pressed;
//   two or more bits low means ghost/multi-press and counts as none pressed.
//  FSM (transitions only on tick, except EMIT):
//   SCAN:   valid sample -> latch row_idx, keep col_idx, deb_cnt=0, go DEBOUNCE
//           (DEBOUNCE_CYCLES==1 -> go EMIT directly).
//           Otherwise col_idx = col_idx+1 (wraps 3->0).
//   DEBOUNCE: col_idx held. Same single row low -> deb_cnt+1; on reaching
//           DEBOUNCE_CYCLES-1 -> EMIT. Any other sample -> SCAN, col_idx+1.
//   EMIT:   lasts one clock. key <= code(row_idx,col_idx), key_valid=1, key_held<=1,
//           rel_cnt=0 -> WAIT_RELEASE.
//   WAIT_RELEASE: col_idx held. All-high sample -> rel_cnt+1, otherwise rel_cnt=0.
//           On reaching DEBOUNCE_CYCLES -> key_held<=0, col_idx+1, go SCAN.
//           No new key is accepted in this state, including a different key in the same column.
//  key_valid and key are registered. key_valid is high only in the clock after the tick that
//   completes the debounce; it is never high on two consecutive clocks.
//  Press latency: DEBOUNCE_CYCLES ticks from first valid sample, plus 1 clock.
//  Code map: row0: 1,2,3,A(10); row1: 4,5,6,B(11); row2: 7,8,9,C(12);
//   row3: *(14),0,#(15),D(13). Columns are 0..3 left to right.
//  Key release and re-press of the same key produce a new pulse with the same code.
//  Reset mid-operation: immediate return to reset values. An in-flight press is discarded,
//   no pulse is emitted.
// TESTING (bench: SCAN_DIV=4, DEBOUNCE_CYCLES=3, keypad model pulls row low when its
//  column is driven low)
//  1 Reset: after reset drop, col_out=1110, key=0, key_valid=0.
//    Then with no press, col_out cycles 1101,1011,0111,1110 every 4 clocks.
//  2 Hold '5' (r1,c1) 200 clks -> exactly one key_valid pulse, key=5, key_held=1,
//    col_out frozen at 1101. Release -> key_held=0 after 3 all-high ticks, scan resumes.
//  3 Bounce: press '7' for 1 tick, release, repeat x5 -> no key_valid, scan keeps cycling.
//  4 '1' and '4' pressed together (r0+r1 in c0) -> no key_valid. Release '1' -> single
//    pulse key=4.
//  5 Hold '#', then also press '0' before releasing '#' -> single pulse key=15 only.
//    Release both, then press 'A' -> pulse key=10. Press '*' -> 14, press 'D' -> 13.
//  6 Assert reset during DEBOUNCE of '9' -> outputs to reset values, no pulse.
//    Keep '9' held through reset release -> a fresh full debounce, then one pulse key=9.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one column at a time,
// synchronises and debounces the rows, and emits a single key_valid pulse with a
// 4-bit key code per accepted press. A new key is only accepted after the
// previous one has been released (debounced).
module keypad_scanner #(
  parameter int SCAN_DIV        = 4096,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DEB_FULL = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    EMIT,
    WAIT_RELEASE
  } state_t;

  state_t        state;
  logic [3:0]    sync_meta;
  logic [3:0]    rows_s;
  logic [DW-1:0] div;
  logic          tick;
  logic [1:0]    col_idx;
  logic [1:0]    row_idx;
  logic [CW-1:0] deb_cnt;
  logic [CW-1:0] rel_cnt;
  logic          sample_single;
  logic [1:0]    sample_row;
  logic          all_high;

  // Keypad code for a (row, col) position; columns run left to right.
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'd0;
    case ({row, col})
      4'h0: code = 4'd1;
      4'h1: code = 4'd2;
      4'h2: code = 4'd3;
      4'h3: code = 4'd10;
      4'h4: code = 4'd4;
      4'h5: code = 4'd5;
      4'h6: code = 4'd6;
      4'h7: code = 4'd11;
      4'h8: code = 4'd7;
      4'h9: code = 4'd8;
      4'hA: code = 4'd9;
      4'hB: code = 4'd12;
      4'hC: code = 4'd14;
      4'hD: code = 4'd0;
      4'hE: code = 4'd15;
      4'hF: code = 4'd13;
      default: code = 4'd0;
    endcase
    return code;
  endfunction

  // Two-flop synchroniser for the asynchronous keypad rows.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_meta <= 4'hF;
      rows_s    <= 4'hF;
    end else begin
      sync_meta <= row_in;
      rows_s    <= sync_meta;
    end
  end

  // Free-running scan divider; the last count of each period is the scan tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  assign tick    = (div == DIV_LAST);
  assign col_out = ~(4'b0001 << col_idx);
  assign all_high = (rows_s == 4'hF);

  // Classify the synchronised rows: exactly one low row is a usable sample,
  // anything else (none or a ghost/multi-press) counts as nothing pressed.
  always_comb begin
    sample_single = 1'b0;
    sample_row    = 2'd0;
    case (rows_s)
      4'b1110: begin sample_single = 1'b1; sample_row = 2'd0; end
      4'b1101: begin sample_single = 1'b1; sample_row = 2'd1; end
      4'b1011: begin sample_single = 1'b1; sample_row = 2'd2; end
      4'b0111: begin sample_single = 1'b1; sample_row = 2'd3; end
      default: begin sample_single = 1'b0; sample_row = 2'd0; end
    endcase
  end

  // Scan/debounce/emit/release state machine with registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
      key       <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (tick) begin
            if (sample_single) begin
              row_idx <= sample_row;
              deb_cnt <= '0;
              if (DEBOUNCE_CYCLES == 1) begin
                key       <= key_code(sample_row, col_idx);
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                state     <= EMIT;
              end else begin
                state <= DEBOUNCE;
              end
            end else begin
              col_idx <= col_idx + 2'd1;
            end
          end
        end
        DEBOUNCE: begin
          if (tick) begin
            if (sample_single && (sample_row == row_idx)) begin
              deb_cnt <= deb_cnt + CW'(1);
              if (deb_cnt + CW'(1) == DEB_LAST) begin
                key       <= key_code(row_idx, col_idx);
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                state     <= EMIT;
              end
            end else begin
              col_idx <= col_idx + 2'd1;
              state   <= SCAN;
            end
          end
        end
        EMIT: begin
          rel_cnt <= '0;
          state   <= WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (tick) begin
            if (all_high) begin
              if (rel_cnt + CW'(1) == DEB_FULL) begin
                rel_cnt  <= '0;
                key_held <= 1'b0;
                col_idx  <= col_idx + 2'd1;
                state    <= SCAN;
              end else begin
                rel_cnt <= rel_cnt + CW'(1);
              end
            end else begin
              rel_cnt <= '0;
            end
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule
